// File: rtl/adc_sampled_scan.sv
// Clocked multi-channel behavioural ADC: sample, fixed-latency convert, clamped quantize, valid/ready output.
// Define ADC_CLIP_FLAG_EN to add the o_clip output flagging clamped results.
//
// state   | meaning
// IDLE    | waiting for a registered start request
// SAMPLE  | one cycle; the exit edge captures i_ana[ch]
// CONVERT | conversion counter running; result computed at terminal count
// HOLD    | result computed, waiting for the output slot to free
module adc_sampled_scan #(
    parameter int  ADC_WIDTH      = 8,
    parameter int  NUM_CH         = 4,
    parameter real FullScaleRange = 1.0,
    parameter int  ConvCycles     = 4,
    localparam int CH_WIDTH       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  real                  i_ana [NUM_CH],
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic [CH_WIDTH-1:0]  i_ch,
    output logic                 o_busy,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ADC_WIDTH-1:0] o_data,
    output logic [CH_WIDTH-1:0]  o_ch
`ifdef ADC_CLIP_FLAG_EN
    ,
    output logic                 o_clip
`endif
);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, HOLD} state_t;

    localparam int MaxCode = (1 << ADC_WIDTH) - 1;

    state_t               state;
    logic                 start_q;
    logic                 mode_q;
    logic [CH_WIDTH-1:0]  ch_req;
    logic [CH_WIDTH-1:0]  ch_sat;
    logic                 mode;
    logic [CH_WIDTH-1:0]  ch;
    logic [15:0]          cnt;
    real                  sample;
    real                  scaled;
    logic [ADC_WIDTH-1:0] q_code;
    logic [ADC_WIDTH-1:0] hold_code;
    logic                 slot_free;
    logic                 last_ch;
`ifdef ADC_CLIP_FLAG_EN
    logic                 q_clip;
    logic                 hold_clip;
`endif

    assign o_busy    = (state != IDLE);
    assign slot_free = !o_valid || i_ready;
    assign last_ch   = !mode || (int'(ch) == NUM_CH - 1);
    assign ch_sat    = (int'(ch_req) >= NUM_CH) ? CH_WIDTH'(NUM_CH - 1) : ch_req;
    assign scaled    = sample * real'(MaxCode) / FullScaleRange;

    // Clamp in the real domain so out-of-range samples never reach $rtoi.
    always_comb begin
        q_code = '0;
`ifdef ADC_CLIP_FLAG_EN
        q_clip = 1'b0;
`endif
        if (scaled < 0.0) begin
`ifdef ADC_CLIP_FLAG_EN
            q_clip = 1'b1;
`endif
        end else if ($floor(scaled) > real'(MaxCode)) begin
            q_code = '1;
`ifdef ADC_CLIP_FLAG_EN
            q_clip = 1'b1;
`endif
        end else begin
            q_code = ADC_WIDTH'($rtoi($floor(scaled)));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            mode_q    <= 1'b0;
            ch_req    <= '0;
            mode      <= 1'b0;
            ch        <= '0;
            cnt       <= '0;
            sample    <= 0.0;
            hold_code <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_ch      <= '0;
`ifdef ADC_CLIP_FLAG_EN
            hold_clip <= 1'b0;
            o_clip    <= 1'b0;
`endif
        end else begin
            // Request register: a start seen outside IDLE never survives into IDLE.
            start_q <= i_start && (state == IDLE);
            mode_q  <= i_mode;
            ch_req  <= i_ch;

            if (o_valid && i_ready) o_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_q) begin
                        mode  <= mode_q;
                        ch    <= mode_q ? '0 : ch_sat;
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    sample <= i_ana[ch];
                    cnt    <= 16'(ConvCycles - 1);
                    state  <= CONVERT;
                end
                CONVERT: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (slot_free) begin
                        o_valid <= 1'b1;
                        o_data  <= q_code;
                        o_ch    <= ch;
`ifdef ADC_CLIP_FLAG_EN
                        o_clip  <= q_clip;
`endif
                        if (last_ch) begin
                            state <= IDLE;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= SAMPLE;
                        end
                    end else begin
                        hold_code <= q_code;
`ifdef ADC_CLIP_FLAG_EN
                        hold_clip <= q_clip;
`endif
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        o_valid <= 1'b1;
                        o_data  <= hold_code;
                        o_ch    <= ch;
`ifdef ADC_CLIP_FLAG_EN
                        o_clip  <= hold_clip;
`endif
                        if (last_ch) begin
                            state <= IDLE;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= SAMPLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sampled_scan.sv
// Self-checking bench for adc_sampled_scan: vector table of single conversions plus scan,
// backpressure, capture-timing and async-reset sequences, checked through a result scoreboard.
module tb_adc_sampled_scan;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    real        ana [N];
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] ch = 2'd0;
    logic       busy;
    logic       valid;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic [1:0] och;
`ifdef ADC_CLIP_FLAG_EN
    logic       clip;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct packed {
        logic [7:0] code;
        logic [1:0] ch;
        logic       clip;
    } exp_t;

    typedef struct {
        real        v;
        int         chn;
        logic [7:0] code;
        logic       clip;
    } vec_t;

    exp_t sb[$];
    int   acc_cyc[$];
    vec_t vecs[7];

    adc_sampled_scan dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ana   (ana),
        .i_start (start),
        .i_mode  (mode),
        .i_ch    (ch),
        .o_busy  (busy),
        .o_valid (valid),
        .i_ready (ready),
        .o_data  (data),
        .o_ch    (och)
`ifdef ADC_CLIP_FLAG_EN
        ,
        .o_clip  (clip)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: every cycle o_valid is high it must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got data=%0d ch=%0d, expected no result", data, och);
            end else begin
                chk("o_data", 32'(data), 32'(sb[0].code));
                chk("o_ch", 32'(och), 32'(sb[0].ch));
`ifdef ADC_CLIP_FLAG_EN
                chk("o_clip", 32'(clip), 32'(sb[0].clip));
`endif
                if (ready) begin
                    void'(sb.pop_front());
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] code, input int c, input logic cl);
        exp_t e;
        e.code = code;
        e.ch   = c[1:0];
        e.clip = cl;
        sb.push_back(e);
    endtask

    // Returns one tick after the edge that registers i_start.
    task automatic pulse_start(input logic m, input int c);
        @(posedge clk); #1;
        mode  = m;
        ch    = c[1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int k;
        foreach (ana[i]) ana[i] = 0.0;

        vecs[0] = '{0.5,   2, 8'd127, 1'b0};
        vecs[1] = '{-0.3,  0, 8'd0,   1'b1};
        vecs[2] = '{1.0,   1, 8'd255, 1'b0};
        vecs[3] = '{0.999, 3, 8'd254, 1'b0};
        vecs[4] = '{1.0e12, 0, 8'd255, 1'b1};
        vecs[5] = '{0.25,  1, 8'd63,  1'b0};
        vecs[6] = '{0.9,   2, 8'd229, 1'b0};

        #12;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ch", 32'(och), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-channel conversions: latency, one-cycle valid, idle afterwards.
        for (int i = 0; i < 7; i++) begin
            ana[vecs[i].chn] = vecs[i].v;
            push_exp(vecs[i].code, vecs[i].chn, vecs[i].clip);
            pulse_start(1'b0, vecs[i].chn);
            wait_valid(k);
            chk("single_latency", 32'(k), 32'd6);
            chk("single_busy_after", 32'(busy), 32'd0);
            @(posedge clk); #1;
            chk("single_valid_pulse", 32'(valid), 32'd0);
            wait_drain("single_drain", 5);
        end

        // Unstalled scan: four results, five cycles apart, busy falls after the last.
        ana[0] = 0.0; ana[1] = 0.25; ana[2] = 0.75; ana[3] = 1.0;
        push_exp(8'd0, 0, 1'b0);
        push_exp(8'd63, 1, 1'b0);
        push_exp(8'd191, 2, 1'b0);
        push_exp(8'd255, 3, 1'b0);
        acc_cyc.delete();
        pulse_start(1'b1, 2);
        @(posedge clk); #1;
        chk("scan_busy", 32'(busy), 32'd1);
        wait_drain("scan_drain", 60);
        chk("scan_count", 32'(acc_cyc.size()), 32'd4);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("scan_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);
        chk("scan_busy_end", 32'(busy), 32'd0);

        // Backpressure: first result held for 30 cycles, then all four drain in order.
        ana[0] = 0.1; ana[1] = 0.3; ana[2] = 0.7; ana[3] = 0.9;
        push_exp(8'd25, 0, 1'b0);
        push_exp(8'd76, 1, 1'b0);
        push_exp(8'd178, 2, 1'b0);
        push_exp(8'd229, 3, 1'b0);
        ready = 1'b0;
        pulse_start(1'b1, 0);
        repeat (30) @(posedge clk);
        #1;
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_pending", 32'(sb.size()), 32'd4);
        ready = 1'b1;
        wait_drain("stall_drain", 60);
        @(posedge clk); #1;
        chk("stall_busy_end", 32'(busy), 32'd0);

        // Capture timing: input steps after the SAMPLE edge; a start while busy is ignored.
        ana[0] = 0.2;
        push_exp(8'd51, 0, 1'b0);
        pulse_start(1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ana[0] = 0.8;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("step_drain", 32'(sb.size()), 32'd0);
        chk("step_busy_idle", 32'(busy), 32'd0);

        // Async reset mid-CONVERT while a result is also held in the output register.
        ready  = 1'b0;
        ana[3] = 0.75;
        push_exp(8'd191, 3, 1'b0);
        pulse_start(1'b0, 3);
        repeat (8) @(posedge clk);
        #1;
        ana[0] = 0.9;
        pulse_start(1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_data", 32'(data), 32'd0);
        chk("async_rst_ch", 32'(och), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        ready  = 1'b1;
        ana[1] = 0.5;
        push_exp(8'd127, 1, 1'b0);
        pulse_start(1'b0, 1);
        wait_valid(k);
        chk("post_rst_latency", 32'(k), 32'd6);
        wait_drain("post_rst_drain", 5);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
